square_bounce_render: RTL

//  Pixel-generation stage directly downstream of the 480p display timing generator.

---
 rtl/square_bounce_render_pkg.sv | 40 ++++
 rtl/square_bounce_render_motion.sv | 105 ++++++++++
 rtl/square_bounce_render.sv | 80 ++++++++
 3 files changed

// File: rtl/square_bounce_render_pkg.sv
// Shared definitions for the bouncing-square pixel stage: colour types,
// palette, background colour, sync idle level and motion direction.
package square_bounce_render_pkg;

    localparam int         RGB_W     = 2;
    localparam logic       SYNC_IDLE = 1'b1;
    localparam logic [2:0] COL_RESET = 3'd1;

    typedef logic [RGB_W-1:0] chan_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } rgb_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam rgb_t RGB_OFF   = '0;
    localparam rgb_t BG_COLOUR = '{r: 2'b00, g: 2'b00, b: 2'b01};

    function automatic rgb_t palette(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: 2'b11, g: 2'b11, b: 2'b11};
            3'd1:    c = '{r: 2'b11, g: 2'b00, b: 2'b00};
            3'd2:    c = '{r: 2'b00, g: 2'b11, b: 2'b00};
            3'd3:    c = '{r: 2'b00, g: 2'b00, b: 2'b11};
            3'd4:    c = '{r: 2'b11, g: 2'b11, b: 2'b00};
            3'd5:    c = '{r: 2'b00, g: 2'b11, b: 2'b11};
            3'd6:    c = '{r: 2'b11, g: 2'b00, b: 2'b11};
            default: c = '{r: 2'b10, g: 2'b10, b: 2'b10};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/square_bounce_render_motion.sv
// Square position, direction and colour state. Moves once per enabled frame
// pulse and bounces off the screen edges, stepping the colour on any bounce.
module square_motion
    import square_bounce_render_pkg::*;
#(
    parameter int CORDW    = 16,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int Q_SIZE   = 32,
    parameter int SPEED    = 2,
    parameter int MOVE_DIV = 0
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    frame_i,
    input  logic                    pause_i,
    output logic signed [CORDW-1:0] qx_o,
    output logic signed [CORDW-1:0] qy_o,
    output logic [2:0]              col_idx_o
);

    localparam logic signed [CORDW-1:0] XMAX = CORDW'(H_RES - Q_SIZE);
    localparam logic signed [CORDW-1:0] YMAX = CORDW'(V_RES - Q_SIZE);
    localparam logic signed [CORDW-1:0] STEP = CORDW'(SPEED);

    logic signed [CORDW-1:0] qx_q, qx_d, qy_q, qy_d;
    dir_t                    dx_q, dx_d, dy_q, dy_d;
    logic [2:0]              col_q, col_d;
    logic                    div_zero;
    logic                    step;
    logic                    x_bounce, y_bounce;

    // The divider counts every frame pulse, paused or not.
    if (MOVE_DIV > 0) begin : g_div
        logic [MOVE_DIV-1:0] div_q;
        always_ff @(posedge clk_pix) begin
            if (rst_pix)      div_q <= '0;
            else if (frame_i) div_q <= div_q + 1'b1;
        end
        assign div_zero = (div_q == '0);
    end else begin : g_nodiv
        assign div_zero = 1'b1;
    end

    assign step = frame_i && div_zero && !pause_i;

    always_comb begin
        qx_d     = qx_q;
        qy_d     = qy_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        col_d    = col_q;
        x_bounce = 1'b0;
        y_bounce = 1'b0;
        if (step) begin
            if (dx_q == DIR_POS) begin
                if (qx_q + STEP >= XMAX) begin
                    qx_d = XMAX; dx_d = DIR_NEG; x_bounce = 1'b1;
                end else begin
                    qx_d = qx_q + STEP;
                end
            end else if (qx_q <= STEP) begin
                qx_d = '0; dx_d = DIR_POS; x_bounce = 1'b1;
            end else begin
                qx_d = qx_q - STEP;
            end

            if (dy_q == DIR_POS) begin
                if (qy_q + STEP >= YMAX) begin
                    qy_d = YMAX; dy_d = DIR_NEG; y_bounce = 1'b1;
                end else begin
                    qy_d = qy_q + STEP;
                end
            end else if (qy_q <= STEP) begin
                qy_d = '0; dy_d = DIR_POS; y_bounce = 1'b1;
            end else begin
                qy_d = qy_q - STEP;
            end

            // A corner hit still advances the colour by one.
            if (x_bounce || y_bounce) col_d = col_q + 3'd1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            qx_q  <= '0;
            qy_q  <= '0;
            dx_q  <= DIR_POS;
            dy_q  <= DIR_POS;
            col_q <= COL_RESET;
        end else begin
            qx_q  <= qx_d;
            qy_q  <= qy_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            col_q <= col_d;
        end
    end

    assign qx_o      = qx_q;
    assign qy_o      = qy_q;
    assign col_idx_o = col_q;

endmodule

// File: rtl/square_bounce_render.sv
// Pixel stage after the 480p timing generator: draws one bouncing square and
// registers RGB together with the syncs so they stay aligned.
module square_bounce_render
    import square_bounce_render_pkg::*;
#(
    parameter int CORDW    = 16,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int Q_SIZE   = 32,
    parameter int SPEED    = 2,
    parameter int MOVE_DIV = 0
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    de,
    input  logic                    frame,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    pause,
    output logic [RGB_W-1:0]        vga_r,
    output logic [RGB_W-1:0]        vga_g,
    output logic [RGB_W-1:0]        vga_b,
    output logic                    hsync,
    output logic                    vsync
);

    localparam logic signed [CORDW-1:0] QSZ = CORDW'(Q_SIZE);

    logic signed [CORDW-1:0] qx, qy;
    logic [2:0]              col_idx;
    logic                    in_sq;
    rgb_t                    rgb_q, rgb_d;
    logic                    hsync_q, vsync_q;

    square_motion #(
        .CORDW    (CORDW),
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .Q_SIZE   (Q_SIZE),
        .SPEED    (SPEED),
        .MOVE_DIV (MOVE_DIV)
    ) u_motion (
        .clk_pix   (clk_pix),
        .rst_pix   (rst_pix),
        .frame_i   (frame),
        .pause_i   (pause),
        .qx_o      (qx),
        .qy_o      (qy),
        .col_idx_o (col_idx)
    );

    assign in_sq = (sx >= qx) && (sx < qx + QSZ) && (sy >= qy) && (sy < qy + QSZ);

    always_comb begin
        rgb_d = BG_COLOUR;
        if (!de)        rgb_d = RGB_OFF;
        else if (in_sq) rgb_d = palette(col_idx);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            rgb_q   <= RGB_OFF;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_in;
            vsync_q <= vsync_in;
        end
    end

    assign vga_r = rgb_q.r;
    assign vga_g = rgb_q.g;
    assign vga_b = rgb_q.b;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule
